// File: rtl/dm_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// dm_access_unit_pkg
//   Shared definitions for the EX_DM data-memory access unit:
//   - dm_state_e : 2-bit access FSM encoding (IDLE / REQ / DONE)
//   - DM_POISON  : value returned to the pipeline when a load times out
// -----------------------------------------------------------------------------
package dm_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  localparam logic [15:0] DM_POISON = 16'hDEAD;

endpackage

// File: rtl/dm_timeout_cnt.sv
// -----------------------------------------------------------------------------
// dm_timeout_cnt
//   8-bit request-wait counter with synchronous clear and count enable.
//   o_tc is high while the count equals TIMEOUT-1, i.e. during the last cycle
//   a request is allowed to wait for its acknowledge.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   i_clr in  clear count to zero (has priority over i_en)
//   i_en  in  increment count
//   o_tc  out terminal count reached
// -----------------------------------------------------------------------------
module dm_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
//   EX_DM-stage data-memory access unit. Converts a pipelined load/store into a
//   req/ack transaction to a variable-latency memory and stalls the pipeline
//   until the transaction completes (or times out).
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   dm_re_EX_DM         load in EX_DM
//   dm_we_EX_DM         store in EX_DM
//   dst_EX_DM           effective address
//   p1_EX_DM            store data
//   stall_DM            freeze PC and pipeline registers this cycle
//   dm_rd_data_EX_DM    last completed load value (to writeback mux)
//   dm_err              sticky error: timeout or load/store conflict
//   mem_req/mem_we/mem_addr/mem_wdata   memory request, held until mem_ack
//   mem_ack/mem_rdata   one-cycle completion pulse and read data
// -----------------------------------------------------------------------------
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_re_EX_DM,
  input  logic              dm_we_EX_DM,
  input  logic [ADDR_W-1:0] dst_EX_DM,
  input  logic [DATA_W-1:0] p1_EX_DM,
  output logic              stall_DM,
  output logic [DATA_W-1:0] dm_rd_data_EX_DM,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] POISON = DATA_W'(DM_POISON);

  dm_state_e         r_state, w_state_next;
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_next;
  logic              r_err, w_err_next;
  logic              w_access;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_tc;

  assign w_access = dm_re_EX_DM | dm_we_EX_DM;

  // DONE is the single cycle in which the pipeline is allowed to advance.
  assign stall_DM = w_access & (r_state != ST_DONE);

  dm_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_rd_data   <= w_rd_data_next;
      r_err       <= w_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_rd_data_next   = r_rd_data;
    w_err_next       = r_err;
    w_cnt_clr        = 1'b0;
    w_cnt_en         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_state_next     = ST_REQ;
          w_mem_req_next   = 1'b1;
          // A simultaneous load/store is issued as the store and flagged.
          w_mem_we_next    = dm_we_EX_DM;
          w_mem_addr_next  = dst_EX_DM;
          w_mem_wdata_next = p1_EX_DM;
          w_err_next       = r_err | (dm_re_EX_DM & dm_we_EX_DM);
          w_cnt_clr        = 1'b1;
        end
      end
      ST_REQ: begin
        // Acknowledge takes priority over a coincident timeout.
        if (mem_ack) begin
          w_state_next   = ST_DONE;
          w_mem_req_next = 1'b0;
          if (!r_mem_we) begin
            w_rd_data_next = mem_rdata;
          end
        end else if (w_tc) begin
          w_state_next   = ST_DONE;
          w_mem_req_next = 1'b0;
          w_err_next     = 1'b1;
          // Stores never touch the load-data register, even when aborted.
          if (!r_mem_we) begin
            w_rd_data_next = POISON;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_req          = r_mem_req;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign dm_rd_data_EX_DM = r_rd_data;
  assign dm_err           = r_err;

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
//   Directed bench for dm_access_unit (TIMEOUT = 4). The driver describes each
//   transaction by its ack cycle; expected outputs are derived from the
//   transaction-level rules (stall for access cycle plus every request cycle,
//   request for ack_at or TIMEOUT cycles, load data/poison visible from DONE).
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_re, dm_we;
  logic [15:0] dst, p1;
  logic        stall_DM, dm_err, mem_req, mem_we, mem_ack;
  logic [15:0] dm_rd_data, mem_addr, mem_wdata, mem_rdata;

  dm_access_unit #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dm_re_EX_DM     (dm_re),
    .dm_we_EX_DM     (dm_we),
    .dst_EX_DM       (dst),
    .p1_EX_DM        (p1),
    .stall_DM        (stall_DM),
    .dm_rd_data_EX_DM(dm_rd_data),
    .dm_err          (dm_err),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic        chk_on = 1'b0;
  logic        exp_stall, exp_req, exp_we;
  logic [15:0] exp_addr, exp_wdata;
  logic [15:0] m_rd;
  logic        m_err;

  // Observations used by the literal checks
  int          stall_seen, req_seen;
  logic        last_we;
  logic [15:0] last_addr, last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Single per-cycle compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall_DM", {31'd0, stall_DM}, {31'd0, exp_stall});
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      chk("rd_data", {16'd0, dm_rd_data}, {16'd0, m_rd});
      chk("dm_err", {31'd0, dm_err}, {31'd0, m_err});
      if (exp_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
        if (exp_we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
      end
      if (stall_DM) stall_seen++;
      if (mem_req) begin
        req_seen++;
        last_we    = mem_we;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
      end
    end
  end

  // One access; ack_at = REQ cycle (1-based) carrying mem_ack, 0 = never.
  // Returns right after the DONE cycle's closing edge with inputs unchanged.
  task automatic do_txn(input logic re, input logic we, input logic [15:0] addr,
                        input logic [15:0] wd, input int ack_at, input logic [15:0] rd);
    int n;
    n = (ack_at == 0) ? TIMEOUT : ack_at;
    stall_seen = 0;
    req_seen   = 0;
    dm_re = re; dm_we = we; dst = addr; p1 = wd;
    exp_stall = 1'b1;
    exp_req   = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= n; i++) begin
      exp_req   = 1'b1;
      exp_we    = we;
      exp_addr  = addr;
      exp_wdata = wd;
      if (re && we) m_err = 1'b1;
      mem_ack   = (i == ack_at);
      mem_rdata = (i == ack_at) ? rd : 16'($urandom);
      @(posedge clk); #1;
    end
    mem_ack   = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    if (!we) m_rd = (ack_at != 0) ? rd : 16'hDEAD;
    if (ack_at == 0) m_err = 1'b1;
    @(posedge clk); #1;
    $display("txn re=%0b we=%0b addr=%h wdata=%h ack_at=%0d -> stall=%0d req=%0d rd=%h err=%0b",
             re, we, addr, wd, ack_at, stall_seen, req_seen, dm_rd_data, dm_err);
  endtask

  task automatic idle(input int n);
    dm_re = 1'b0; dm_we = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    dm_re = 1'b0; dm_we = 1'b0; dst = '0; p1 = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wdata = '0;
    m_rd = '0; m_err = 1'b0;
    stall_seen = 0; req_seen = 0;
    last_we = 1'b0; last_addr = '0; last_wdata = '0;
    chk_on = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Load 0x0040, ack on 3rd REQ cycle.
    do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'h1234);
    idle(1);
    chk("load_rd_lit", {16'd0, dm_rd_data}, 32'h1234);
    chk("load_stall_cycles", stall_seen, 4);
    chk("load_req_cycles", req_seen, 3);

    // Store 0xBEEF to 0x0010, ack on 1st cycle.
    do_txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h7777);
    idle(1);
    chk("store_we_lit", {31'd0, last_we}, 32'd1);
    chk("store_wdata_lit", {16'd0, last_wdata}, 32'hBEEF);
    chk("store_rd_kept", {16'd0, dm_rd_data}, 32'h1234);

    // Load then load, back to back.
    do_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'hA5A5);
    chk("b2b1_req_cycles", req_seen, 1);
    do_txn(1'b1, 1'b0, 16'h0102, 16'h0000, 1, 16'h5A5A);
    chk("b2b2_req_cycles", req_seen, 1);
    chk("b2b2_stall_cycles", stall_seen, 2);
    idle(1);
    chk("b2b_rd_lit", {16'd0, dm_rd_data}, 32'h5A5A);

    // Load and store together: issued as write, error raised.
    do_txn(1'b1, 1'b1, 16'h0002, 16'h00C3, 2, 16'h1111);
    idle(1);
    chk("conflict_we_lit", {31'd0, last_we}, 32'd1);
    chk("conflict_addr_lit", {16'd0, last_addr}, 32'h0002);
    chk("conflict_err_lit", {31'd0, dm_err}, 32'd1);
    chk("conflict_rd_kept", {16'd0, dm_rd_data}, 32'h5A5A);

    // Load with no ack: times out after TIMEOUT request cycles.
    do_txn(1'b1, 1'b0, 16'h0200, 16'h0000, 0, 16'h0000);
    idle(3);
    chk("timeout_req_cycles", req_seen, 4);
    chk("timeout_rd_lit", {16'd0, dm_rd_data}, 32'hDEAD);
    chk("timeout_err_sticky", {31'd0, dm_err}, 32'd1);

    // Reset while a request is outstanding.
    stall_seen = 0; req_seen = 0;
    dm_re = 1'b1; dst = 16'h0080;
    exp_stall = 1'b1; exp_req = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 16'h0080;
    @(posedge clk); #2;
    rst = 1'b1;
    dm_re = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; m_rd = '0; m_err = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, stall_DM}, 32'd0);
    chk("async_rst_err", {31'd0, dm_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset mid-request addr=0080 -> req=%0b err=%0b", mem_req, dm_err);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    idle(2);
    chk("late_ack_rd", {16'd0, dm_rd_data}, 32'h0000);

    // Normal load after reset.
    do_txn(1'b1, 1'b0, 16'h0300, 16'h0000, 2, 16'hC0DE);
    idle(2);
    chk("post_rst_rd_lit", {16'd0, dm_rd_data}, 32'hC0DE);
    chk("post_rst_err_lit", {31'd0, dm_err}, 32'd0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
